// File: rtl/inst_rom_server.sv
// inst_rom_server: instruction ROM responder for the CPU fetch port, with a
// byte-serial program loader that fills the word array before the CPU runs.
// A fetch answers after LATENCY wait states with a one-cycle rom_ready_o pulse.
// Optional feature, macro INST_ROM_BOUNDS_CHK_EN: out-of-range fetches return
// NOP_WORD with rom_err_o, and fetches beyond the loaded words return NOP_WORD.
// Without the macro the index wraps modulo depth and rom_err_o stays 0.
module inst_rom_server #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_ce_i,
    input  logic [31:0]           rom_addr_i,
    output logic [31:0]           rom_data_o,
    output logic                  rom_ready_o,
    output logic                  rom_err_o,
    input  logic                  prog_en_i,
    input  logic                  prog_valid_i,
    input  logic [7:0]            prog_byte_i,
    output logic                  prog_ready_o,
    output logic [DEPTH_LOG2:0]   prog_words_o
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WCNT_W = DEPTH_LOG2 + 1;
    localparam int unsigned WADR_W = 30;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_LOAD = 2'd3;

    logic [1:0]            state_q,  state_d;
    logic [WADR_W-1:0]     addr_q,   addr_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [31:0]           data_q;
    logic                  ready_q,  ready_d;
    logic                  err_q,    err_d;
    logic                  pready_q, pready_d;
    logic [WCNT_W-1:0]     words_q,  words_d;
    logic [1:0]            ptr_q,    ptr_d;
    logic [31:0]           asm_q,    asm_d;

    logic [31:0]           mem_q [DEPTH];

    logic                  accept_c;
    logic                  commit_c;
    logic [1:0]            ptr_nx_c;
    logic [31:0]           asm_nx_c;
    logic                  mem_we_c;
    logic [31:0]           mem_wdata_c;
    logic [DEPTH_LOG2-1:0] rd_idx_c;
    logic                  oor_c;
    logic                  fetch_nop_c;
    logic                  unused_c;

    // Byte-offset bits never select anything in a word array.
    assign unused_c = ^rom_addr_i[1:0];

    assign accept_c = prog_valid_i & pready_q;
    assign rd_idx_c = addr_d[DEPTH_LOG2-1:0];
    assign oor_c    = (addr_d[WADR_W-1:DEPTH_LOG2] != '0);

`ifdef INST_ROM_BOUNDS_CHK_EN
    assign fetch_nop_c = oor_c | (WCNT_W'(rd_idx_c) >= words_q);
`else
    assign fetch_nop_c = 1'b0;
`endif

    // Next-state, loader assembly and output decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        words_d     = words_q;
        ptr_d       = ptr_q;
        asm_d       = asm_q;
        commit_c    = 1'b0;
        ptr_nx_c    = ptr_q;
        asm_nx_c    = asm_q;
        mem_we_c    = 1'b0;
        mem_wdata_c = '0;

        case (state_q)
            // RESP also accepts the next request so fetches can stream.
            S_IDLE, S_RESP: begin
                if (prog_en_i) begin
                    state_d = S_LOAD;
                end else if (rom_ce_i) begin
                    addr_d  = rom_addr_i[31:2];
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (prog_en_i) begin
                    state_d = S_LOAD;
                end else if (!rom_ce_i) begin
                    state_d = S_IDLE;
                end else if (rom_addr_i[31:2] != addr_q) begin
                    // Redirect: restart the wait for the new address.
                    addr_d = rom_addr_i[31:2];
                    cnt_d  = CNT_W'(LATENCY);
                end else if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_LOAD: begin
                // Assembly register is zero after each commit, so OR fills a lane.
                if (accept_c) begin
                    asm_nx_c = asm_q | (32'(prog_byte_i) << {ptr_q, 3'b000});
                    if (ptr_q == 2'd3) begin
                        commit_c = 1'b1;
                        ptr_nx_c = 2'd0;
                    end else begin
                        ptr_nx_c = ptr_q + 2'd1;
                    end
                end
                if (!prog_en_i) begin
                    state_d = S_IDLE;
                    if (ptr_nx_c != 2'd0) begin
                        commit_c = 1'b1;
                    end
                end
                if (commit_c) begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = asm_nx_c;
                    words_d     = words_q + WCNT_W'(1);
                    asm_d       = '0;
                    ptr_d       = 2'd0;
                end else begin
                    asm_d = asm_nx_c;
                    ptr_d = ptr_nx_c;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d  = (state_d == S_RESP);
`ifdef INST_ROM_BOUNDS_CHK_EN
        err_d    = ready_d & oor_c;
`else
        err_d    = 1'b0;
`endif
        pready_d = (state_d == S_LOAD) && (words_d < WCNT_W'(DEPTH));
    end

    // State and output registers; the read data register updates only on RESP entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            pready_q <= 1'b0;
            words_q  <= '0;
            ptr_q    <= 2'd0;
            asm_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            pready_q <= pready_d;
            words_q  <= words_d;
            ptr_q    <= ptr_d;
            asm_q    <= asm_d;
            if (ready_d) begin
                data_q <= fetch_nop_c ? NOP_WORD : mem_q[rd_idx_c];
            end
        end
    end

    // Word array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we_c) begin
            mem_q[words_q[DEPTH_LOG2-1:0]] <= mem_wdata_c;
        end
    end

    assign rom_data_o   = data_q;
    assign rom_ready_o  = ready_q;
    assign rom_err_o    = err_q;
    assign prog_ready_o = pready_q;
    assign prog_words_o = words_q;

endmodule
